// File: rtl/noc_net_iface.sv
// noc_net_iface: CPU PIO word port <-> circulant-NoC packet port.
// Tx/rx FIFOs, registered router output, status word, sticky flags.

module noc_net_iface #(
  parameter int DEPTH  = 4,
  parameter int ID_W   = 4,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ID_W-1:0]        router_name,
  input  logic [31:0]            cpu_tx,
  output logic [31:0]            cpu_rx,
  input  logic                   cpu_rx_ack,
  output logic [2*ID_W+DATA_W:0] to_r,
  input  logic                   r_accept,
  input  logic [2*ID_W+DATA_W:0] f_r
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = 2*ID_W + DATA_W;
  localparam int RW = ID_W + DATA_W;

  logic          strb_q;
  logic [TW-1:0] txm_q [DEPTH];
  logic [RW-1:0] rxm_q [DEPTH];
  logic [PW-1:0] tx_wr_q, tx_rd_q;
  logic [PW-1:0] rx_wr_q, rx_rd_q;
  logic          ovf_q, ovf_d;
  logic          drop_q, drop_d;
  logic [TW:0]   to_r_q, to_r_d;

  logic          cmd, clr, enq;
  logic          tx_empty, tx_full;
  logic          tx_pop, tx_push, tx_lost;
  logic          rx_empty, rx_full, rx_hit;
  logic          rx_pop, rx_push, rx_lost;
  logic [PW-1:0] tx_cnt, tx_left;
  logic [PW-1:0] tx_rd_nx, tx_hd;
  logic [RW-1:0] rx_head;
  logic          unused_bits;

  assign unused_bits =
    ^{cpu_tx[29:24+ID_W], cpu_tx[23:DATA_W]};

  // Command decode from the strobe rising edge
  always_comb begin
    cmd = cpu_tx[31] & ~strb_q;
    clr = cmd & cpu_tx[30];
    enq = cmd & ~cpu_tx[30];
  end

  // FIFO status, push/pop qualification and loss detection
  always_comb begin
    tx_empty = (tx_wr_q == tx_rd_q);
    tx_full  = (tx_wr_q[AW] != tx_rd_q[AW])
            && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
    tx_pop   = r_accept & to_r_q[TW];
    tx_push  = enq & (~tx_full | tx_pop);
    tx_lost  = enq & tx_full & ~tx_pop;
    rx_empty = (rx_wr_q == rx_rd_q);
    rx_full  = (rx_wr_q[AW] != rx_rd_q[AW])
            && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
    rx_hit   = f_r[TW]
            & (f_r[TW-1 -: ID_W] == router_name);
    rx_pop   = cpu_rx_ack & ~rx_empty;
    rx_push  = rx_hit & (~rx_full | rx_pop);
    rx_lost  = rx_hit & rx_full & ~rx_pop;
  end

  // Next router word: head after this edge's pop, ignoring this edge's write
  always_comb begin
    tx_cnt   = tx_wr_q - tx_rd_q;
    tx_rd_nx = tx_rd_q + PW'(1);
    tx_hd    = tx_pop ? tx_rd_nx : tx_rd_q;
    tx_left  = tx_cnt - PW'(tx_pop);
    to_r_d   = '0;
    if (tx_left != '0)
      to_r_d = {1'b1, txm_q[tx_hd[AW-1:0]]};
  end

  // Sticky flags: a new error wins over a simultaneous clear
  always_comb begin
    ovf_d  = rx_lost | (ovf_q & ~clr);
    drop_d = tx_lost | (drop_q & ~clr);
  end

  // Control state: strobe history, pointers, flags, router output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_q  <= 1'b1;
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
      to_r_q  <= '0;
    end else begin
      strb_q <= cpu_tx[31];
      if (tx_push) tx_wr_q <= tx_wr_q + PW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_nx;
      if (rx_push) rx_wr_q <= rx_wr_q + PW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + PW'(1);
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
      to_r_q <= to_r_d;
    end
  end

  // FIFO storage; validity is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (tx_push)
      txm_q[tx_wr_q[AW-1:0]] <= {cpu_tx[24 +: ID_W],
                                 router_name,
                                 cpu_tx[0 +: DATA_W]};
    if (rx_push)
      rxm_q[rx_wr_q[AW-1:0]] <= f_r[RW-1:0];
  end

  assign rx_head = rxm_q[rx_rd_q[AW-1:0]];

  // Status word built only from registered state
  always_comb begin
    cpu_rx     = '0;
    cpu_rx[31] = ~rx_empty;
    cpu_rx[30] = tx_full;
    cpu_rx[29] = ovf_q;
    cpu_rx[28] = drop_q;
    if (!rx_empty) begin
      cpu_rx[24 +: ID_W]  = rx_head[DATA_W +: ID_W];
      cpu_rx[0 +: DATA_W] = rx_head[0 +: DATA_W];
    end
  end

  assign to_r = to_r_q;

endmodule

// File: doc/noc_net_iface.md
# noc_net_iface

Network interface between a node's local CPU port (32-bit PIO-style inject/eject words) and the 17-bit packet port of its circulant-NoC router. It holds outgoing packets in a transmit FIFO until the router accepts them, and delivers packets addressed to this node through a receive FIFO. It also reports status and sticky error flags to the CPU. One instance sits between each CPU-side agent and its router's `in_free`/`out_data` pair.

## Interface
- `DEPTH`, 4: entries per FIFO; must be a power of two, ≥2.
- `ID_W`, 4: node-id width.
- `DATA_W`, 8: payload width.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `router_name`  in  ID_W  local node id; static after reset.
- `cpu_tx`  in  32  command word: [31] strobe, [30] clear-flags, [27:24] dest, [7:0] payload; other bits ignored.
- `cpu_rx`  out  32  status/data word: [31] rx_valid, [30] tx_full, [29] rx_overflow, [28] tx_drop, [27:24] src, [7:0] payload; other bits 0.
- `cpu_rx_ack`  in  1  one-cycle pulse: pop the rx head.
- `to_r`  out  17  packet to router: [16] valid, [15:12] dest, [11:8] src, [7:0] data.
- `r_accept`  in  1  router consumed `to_r` at this edge.
- `f_r`  in  17  packet from router, same format; [16] high for exactly one cycle per packet.

## Operation
- Command detect:
  - `cpu_tx[31]` is edge-detected; its previous-value register resets to 1, so a strobe already high out of reset is not a command.
  - Rising edge with [30]=1: clear `rx_overflow` and `tx_drop`; nothing is enqueued.
  - Rising edge with [30]=0: enqueue {dest, router_name, payload} into the tx FIFO.
  - Enqueue while tx full: entry dropped, `tx_drop` set — except when `r_accept` pops the tx FIFO at the same edge, in which case the write succeeds.
- Tx path:
  - `to_r` is a register.
  - `to_r[16]` = tx FIFO not empty; fields = head entry.
  - `to_r` is held stable until `r_accept`.
  - `r_accept` while `to_r[16]`=0 is ignored.
- Rx path:
  - On `f_r[16]`=1 with `f_r[15:12]` == `router_name`: push {src, data}.
  - Packets with a different dest are discarded silently; the router owns forwarding.
  - Push while rx full: packet dropped, `rx_overflow` set — unless `cpu_rx_ack` pops at the same edge, in which case both the push and the pop happen.
  - `cpu_rx_ack` while rx empty: ignored.
- Status:
  - `cpu_rx[31]` = rx not empty; [27:24]/[7:0] = rx head, or 0 when empty.
  - `cpu_rx[30]` = tx FIFO full.
  - Sticky flags [29:28] are cleared only by the clear command or by reset.
  - A clear at the same edge as a new error leaves the flag set; set wins.
- FIFO pointers are log2(DEPTH)+1 bits, wrap modulo 2·DEPTH; full/empty come from the MSB compare. No arithmetic overflow is possible elsewhere.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - `to_r`=0, `cpu_rx`=0.
  - Both FIFOs empty, all flags 0, strobe-prev=1.
  - Reset mid-transfer discards all queued packets with no partial output.
- Tx latency: strobe rising edge seen at edge N → `to_r[16]`=1 after edge N+1 (edge register plus FIFO write, then output register).
- Tx throughput: one packet per cycle. When `r_accept` is high at edge M, the next head (or valid=0) appears after edge M.
- Rx latency: `f_r` valid at edge N → `cpu_rx[31]`=1 and head fields updated after edge N.
- Rx pop: `cpu_rx_ack` at edge N → next head or empty status after edge N.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset with `cpu_tx[31]`=1 held, release, keep high → no enqueue, `to_r`=0. Drop to 0, raise with dest=3, payload=0xA5, router_name=1 → two edges later `to_r`=0x1_31A5 (valid=1, dest=3, src=1, data=0xA5), stable until `r_accept`.
- Five strobes with `r_accept`=0, DEPTH=4 → `cpu_rx[30]`=1, `cpu_rx[28]`=1. Then pulse `r_accept` four times → payloads emitted in order and valid drops to 0. Clear command → [28]=0.
- Full tx FIFO, strobe edge coincident with `r_accept` → no drop, FIFO still holds 4 entries, `tx_drop` stays 0.
- `f_r` with dest=1 (local), src=7, data=0x3C → after that edge `cpu_rx`=0x8700_003C. `f_r` with dest=2 → no change.
- Five local packets with no ack → 4 queued, `rx_overflow`=1. Fifth packet arriving together with `cpu_rx_ack` on a full FIFO → accepted, no overflow.
- Assert `rst_n`=0 mid-stream with both FIFOs partly full → `to_r`=0 and `cpu_rx`=0 immediately (async), and both FIFOs are empty after release.
